// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage:
// load/store op codes, FSM states and op classifiers.
package mem_stage_pkg;

    localparam logic [3:0] MemOpNone = 4'd0;
    localparam logic [3:0] MemOpLB   = 4'd1;
    localparam logic [3:0] MemOpLBU  = 4'd2;
    localparam logic [3:0] MemOpLH   = 4'd3;
    localparam logic [3:0] MemOpLHU  = 4'd4;
    localparam logic [3:0] MemOpLW   = 4'd5;
    localparam logic [3:0] MemOpSB   = 4'd6;
    localparam logic [3:0] MemOpSH   = 4'd7;
    localparam logic [3:0] MemOpSW   = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MemOpLB) && (op <= MemOpLW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MemOpSB) && (op <= MemOpSW);
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Big-endian byte-lane steering: byte enables, store
// replication, load extension and misalignment detect.
module mem_lane (
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);
    import mem_stage_pkg::*;

    logic        byte_op;
    logic        half_op;
    logic        word_op;
    logic        sgn;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign byte_op = (op == MemOpLB) || (op == MemOpLBU)
                   || (op == MemOpSB);
    assign half_op = (op == MemOpLH) || (op == MemOpLHU)
                   || (op == MemOpSH);
    assign word_op = (op == MemOpLW) || (op == MemOpSW);
    assign sgn     = (op == MemOpLB) || (op == MemOpLH);

    // {~a,3'b111} equals 31-8a, the MSB of the addressed byte
    assign ld_b = rdata[{~addr, 3'b111} -: 8];
    assign ld_h = addr[1] ? rdata[15:0] : rdata[31:16];

    // Decode access width into lanes and extended load data
    always_comb begin
        sel      = 4'b0000;
        wdata    = sdata;
        ldata    = rdata;
        misalign = 1'b0;
        unique case (1'b1)
            byte_op: begin
                sel   = 4'b1000 >> addr;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sgn & ld_b[7]}}, ld_b};
            end
            half_op: begin
                sel      = addr[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{sgn & ld_h[15]}}, ld_h};
                misalign = addr[0];
            end
            word_op: begin
                sel      = 4'b1111;
                misalign = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the req/ack data bus, stalls while a
// transfer is outstanding and builds the MEM/WB bundle.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_whilo,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        stallreq,
    output logic        excp_misalign,
    output logic        excp_buserr
);
    import mem_stage_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [31:0]   cap;
    logic          discard;

    logic          is_load;
    logic          is_store;
    logic          access;
    logic          mis;
    logic          go;
    logic          busy;
    logic          tmo;
    logic          kill;
    logic          abort;
    logic [3:0]    sel;
    logic [31:0]   lwdata;
    logic [31:0]   ldata;

    assign is_load  = op_is_load(mem_op);
    assign is_store = op_is_store(mem_op);
    assign access   = is_load | is_store;
    assign busy     = (state == StBusy);
    assign go       = (state == StIdle) & access & ~mis & ~flush;
    assign tmo      = (cnt == CW'(TIMEOUT - 1));
    assign kill     = discard | flush;
    // Transfer ends here without reaching DONE
    assign abort    = busy & ((bus_ack & kill) | (~bus_ack & tmo));

    mem_lane u_lane (
        .op       (mem_op),
        .addr     (mem_addr[1:0]),
        .sdata    (mem_sdata),
        .rdata    (cap),
        .sel      (sel),
        .wdata    (lwdata),
        .ldata    (ldata),
        .misalign (mis)
    );

    // Transfer FSM with wait counter, read capture and discard flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            cap     <= '0;
            discard <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    discard <= 1'b0;
                    if (go) begin
                        cnt <= CW'(1);
                        if (bus_ack) begin
                            cap   <= bus_rdata;
                            state <= StDone;
                        end else begin
                            state <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt <= cnt + CW'(1);
                    if (flush) discard <= 1'b1;
                    if (bus_ack) begin
                        cap     <= bus_rdata;
                        discard <= 1'b0;
                        state   <= kill ? StIdle : StDone;
                    end else if (tmo) begin
                        discard <= 1'b0;
                        state   <= StIdle;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Bus, stall, exception and write-back outputs
    always_comb begin
        bus_req       = go | busy;
        bus_we        = (go | busy) & is_store;
        bus_addr      = {mem_addr[31:2], 2'b00};
        bus_sel       = (go | busy) ? sel : 4'b0000;
        bus_wdata     = lwdata;
        stallreq      = go | (busy & ~abort);
        excp_misalign = (state == StIdle) & access & mis & ~flush;
        excp_buserr   = busy & ~bus_ack & tmo & ~kill;
        wb_wd         = mem_wd;
        wb_wreg       = mem_wreg;
        wb_wdata      = mem_wdata;
        wb_hi         = mem_hi;
        wb_lo         = mem_lo;
        wb_whilo      = mem_whilo;
        unique case (state)
            StIdle: begin
                if (flush | excp_misalign) begin
                    wb_wreg  = 1'b0;
                    wb_whilo = 1'b0;
                end
                if (go) wb_wreg = 1'b0;
            end
            StBusy: begin
                wb_wreg = 1'b0;
                if (abort) wb_whilo = 1'b0;
            end
            StDone: begin
                if (is_load) wb_wdata = ldata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test plan
// cases plus randomized accesses against a lane model.
module tb_mem_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        stallreq;
    logic        excp_misalign;
    logic        excp_buserr;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_wd        (mem_wd),
        .mem_wreg      (mem_wreg),
        .mem_wdata     (mem_wdata),
        .mem_hi        (mem_hi),
        .mem_lo        (mem_lo),
        .mem_whilo     (mem_whilo),
        .mem_op        (mem_op),
        .mem_addr      (mem_addr),
        .mem_sdata     (mem_sdata),
        .flush         (flush),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_sel       (bus_sel),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .wb_wd         (wb_wd),
        .wb_wreg       (wb_wreg),
        .wb_wdata      (wb_wdata),
        .wb_hi         (wb_hi),
        .wb_lo         (wb_lo),
        .wb_whilo      (wb_whilo),
        .stallreq      (stallreq),
        .excp_misalign (excp_misalign),
        .excp_buserr   (excp_buserr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 none, 1 byte, 2 half, 3 word
    function automatic int kind(input int op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 3;
        return 0;
    endfunction

    function automatic bit m_load(input int op);
        return op >= 1 && op <= 5;
    endfunction

    function automatic bit m_mis(input int op, input int a);
        return (kind(op) == 2 && (a % 2) != 0) || (kind(op) == 3 && a != 0);
    endfunction

    function automatic logic [3:0] m_sel(input int op, input int a);
        case (kind(op))
            1: return 4'(8 >> a);
            2: return (a == 0) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] sd);
        if (kind(op) == 1) return (sd & 32'hFF) * 32'h01010101;
        if (kind(op) == 2) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load_val(input int op, input int a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        if (kind(op) == 1) begin
            v = (rd >> (8 * (3 - a))) & 32'hFF;
            if (op == 1 && v >= 128) v = v | 32'hFFFFFF00;
        end else if (kind(op) == 2) begin
            v = (rd >> (16 * (1 - a / 2))) & 32'hFFFF;
            if (op == 3 && v >= 32768) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, ".idle_req"}, 32'(bus_req), 32'd0);
        chk({tag, ".idle_stall"}, 32'(stallreq), 32'd0);
        chk({tag, ".idle_wreg"}, 32'(wb_wreg), 32'(mem_wreg));
        chk({tag, ".idle_wdata"}, wb_wdata, mem_wdata);
        chk({tag, ".idle_wd"}, 32'(wb_wd), 32'(mem_wd));
        next_cycle();
    endtask

    // lat: ack arrives lat cycles after the issue cycle; lat>=TMO = never
    // flc: cycle index (>=2) at which flush pulses, 0 for none
    task automatic access(input string tag, input int op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int lat, input int flc);
        int  a;
        int  term;
        bit  acked;
        bit  fl;
        a         = int'(addr[1:0]);
        mem_op    = 4'(op);
        mem_addr  = addr;
        mem_sdata = sd;
        mem_wd    = 5'($urandom_range(1, 31));
        mem_wreg  = m_load(op);
        mem_wdata = $urandom;
        mem_hi    = $urandom;
        mem_lo    = $urandom;
        mem_whilo = 1'b0;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        if (kind(op) == 0) begin
            idle_check(tag);
        end else if (m_mis(op, a)) begin
            mem_whilo = 1'b1;
            @(negedge clk);
            chk({tag, ".mis"}, 32'(excp_misalign), 32'd1);
            chk({tag, ".mis_req"}, 32'(bus_req), 32'd0);
            chk({tag, ".mis_stall"}, 32'(stallreq), 32'd0);
            chk({tag, ".mis_wreg"}, 32'(wb_wreg), 32'd0);
            chk({tag, ".mis_whilo"}, 32'(wb_whilo), 32'd0);
            next_cycle();
            mem_whilo = 1'b0;
            mem_op = 4'd0;
            idle_check(tag);
        end else begin
            acked = (lat < TMO);
            term  = acked ? lat + 1 : TMO;
            fl    = 1'b0;
            for (int c = 1; c <= term; c++) begin
                flush     = (c == flc) && (c >= 2);
                if (flush) fl = 1'b1;
                bus_ack   = acked && (c == term);
                bus_rdata = bus_ack ? rd : $urandom;
                @(negedge clk);
                chk({tag, ".req"}, 32'(bus_req), 32'd1);
                chk({tag, ".we"}, 32'(bus_we), 32'(!m_load(op)));
                chk({tag, ".addr"}, bus_addr, addr & 32'hFFFFFFFC);
                chk({tag, ".sel"}, 32'(bus_sel), 32'(m_sel(op, a)));
                if (!m_load(op))
                    chk({tag, ".bwdata"}, bus_wdata, m_wdata(op, sd));
                chk({tag, ".wreg_busy"}, 32'(wb_wreg), 32'd0);
                chk({tag, ".buserr"}, 32'(excp_buserr),
                    32'(!acked && c == term && !fl));
                chk({tag, ".stall"}, 32'(stallreq),
                    32'(!(c == term && (fl || !acked))));
                next_cycle();
            end
            flush   = 1'b0;
            bus_ack = 1'b0;
            if (acked && !fl) begin
                @(negedge clk);
                chk({tag, ".done_stall"}, 32'(stallreq), 32'd0);
                chk({tag, ".done_req"}, 32'(bus_req), 32'd0);
                chk({tag, ".done_wreg"}, 32'(wb_wreg), 32'(m_load(op)));
                chk({tag, ".done_wdata"}, wb_wdata,
                    m_load(op) ? m_load_val(op, a, rd) : mem_wdata);
                next_cycle();
            end
            mem_op = 4'd0;
            idle_check(tag);
        end
    endtask

    initial begin
        int op;
        int lat;
        int flc;
        rst       = 1'b1;
        mem_wd    = 5'd3;
        mem_wreg  = 1'b1;
        mem_wdata = 32'hCAFE0001;
        mem_hi    = 32'd0;
        mem_lo    = 32'd0;
        mem_whilo = 1'b0;
        mem_op    = 4'd0;
        mem_addr  = 32'd0;
        mem_sdata = 32'd0;
        flush     = 1'b0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rst.req", 32'(bus_req), 32'd0);
        chk("rst.stall", 32'(stallreq), 32'd0);
        chk("rst.mis", 32'(excp_misalign), 32'd0);
        chk("rst.buserr", 32'(excp_buserr), 32'd0);
        chk("rst.wdata", wb_wdata, 32'hCAFE0001);
        next_cycle();
        rst = 1'b0;

        mem_wd    = 5'd5;
        mem_wdata = 32'h1234;
        idle_check("add");

        access("lb", 1, 32'h101, 32'h0, 32'h11AA2233, 1, 0);
        access("lhu", 4, 32'h102, 32'h0, 32'h1234F00D, 0, 0);
        access("sh", 7, 32'h200, 32'hDEADBEEF, 32'h0, 1, 0);
        access("lw_mis", 5, 32'h3, 32'h0, 32'h0, 0, 0);
        access("lw_tmo", 5, 32'h40, 32'h0, 32'h0, TMO, 0);
        access("lw_tmo_fl", 5, 32'h44, 32'h0, 32'h0, TMO, 3);
        access("lw_edge", 5, 32'h48, 32'h0, 32'h89ABCDEF, TMO - 1, 0);
        access("lb_fl_ack", 1, 32'h50, 32'h0, 32'h80000000, 3, 4);
        access("lh_neg", 3, 32'h52, 32'h0, 32'h0000F123, 2, 0);

        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 10);
            case ($urandom_range(0, 5))
                0: lat = 0;
                1: lat = TMO - 1;
                2: lat = TMO;
                default: lat = $urandom_range(1, 4);
            endcase
            flc = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
            access("rnd", op, $urandom, $urandom, $urandom, lat, flc);
        end

        mem_op   = 4'd5;
        mem_addr = 32'h80;
        bus_ack  = 1'b0;
        next_cycle();
        next_cycle();
        rst    = 1'b1;
        mem_op = 4'd0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rstbusy.req", 32'(bus_req), 32'd0);
        chk("rstbusy.stall", 32'(stallreq), 32'd0);
        next_cycle();
        bus_ack   = 1'b1;
        bus_rdata = 32'h55555555;
        @(negedge clk);
        chk("late_ack.stall", 32'(stallreq), 32'd0);
        chk("late_ack.req", 32'(bus_req), 32'd0);
        next_cycle();
        bus_ack = 1'b0;
        idle_check("late_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline register outputs (write-back target, ALU result, HI/LO) together with the load/store op, effective address and store data.
- Drives a req/ack data bus, stalls the pipeline while a transfer is outstanding, and produces the write-back bundle for the MEM/WB register.
- Owns the load sign/zero extension, byte-lane selection, misalignment detection and bus timeout.

Parameters:
- TIMEOUT, 16, ack wait cycles after which an outstanding access is aborted (≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_wd  in  5  destination register address
- mem_wreg  in  1  register write enable
- mem_wdata  in  32  ALU result
- mem_hi  in  32  HI value
- mem_lo  in  32  LO value
- mem_whilo  in  1  HI/LO write enable
- mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others are treated as none
- mem_addr  in  32  effective address
- mem_sdata  in  32  store data (rt)
- flush  in  1  discard the current instruction
- bus_req  out  1  access request
- bus_we  out  1  1 = store
- bus_addr  out  32  word address, low 2 bits forced to 0
- bus_sel  out  4  byte enables, bit3 = addr 0 (big-endian)
- bus_wdata  out  32  store data replicated into lanes
- bus_rdata  in  32  read data
- bus_ack  in  1  transfer complete
- wb_wd  out  5  to MEM/WB
- wb_wreg  out  1  to MEM/WB
- wb_wdata  out  32  to MEM/WB
- wb_hi  out  32  to MEM/WB
- wb_lo  out  32  to MEM/WB
- wb_whilo  out  1  to MEM/WB
- stallreq  out  1  hold IF..EX/MEM
- excp_misalign  out  1  address-error pulse
- excp_buserr  out  1  timeout pulse

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (any state): go to IDLE; clear the capture register, timeout counter and discard flag. All outputs are combinational from state/inputs, so after reset bus_req=0, stallreq=0, both excp outputs=0, and wb_* equal the passthrough of the current inputs.
- IDLE, non-memory op: wb_* = mem_* passthrough; stallreq=0; bus_req=0.
- IDLE, aligned memory op and flush=0:
  - Combinationally: bus_req=1, stallreq=1, wb_wreg=0.
  - Next state is DONE if bus_ack=1 in the same cycle (zero-wait), otherwise BUSY.
  - Counter loads 1.
- BUSY:
  - bus_req=1 and bus signals held stable.
  - stallreq=1, wb_wreg=0.
  - Counter increments each cycle.
  - On bus_ack: capture bus_rdata and go to DONE.
  - If counter reaches TIMEOUT without ack: drop req, pulse excp_buserr for one cycle, go to IDLE with the instruction suppressed (wb_wreg=0).
- DONE: lasts one cycle.
  - stallreq=0, so the pipeline advances at the end of the cycle.
  - Loads: wb_wreg=mem_wreg and wb_wdata=extended captured data. Stores: wb_wdata=mem_wdata.
  - Always returns to IDLE.
- Lane rules (big-endian), a = addr[1:0]:
  - Byte: sel = 1000 >> a; load byte = rdata[31-8a -: 8].
  - Half: sel = 1100 (a=0) or 0011 (a=2); load half = rdata[31:16] or rdata[15:0].
  - Word: sel = 1111.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Store data is replicated: SB {4{b}}, SH {2{h}}.
- Misalignment:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Response: no bus request, excp_misalign=1 in that cycle (combinational), wb_wreg=0, wb_whilo=0, no stall.
- Flush:
  - In IDLE: the op is ignored (no request, wb_wreg=0).
  - In BUSY: set the discard flag. The request is not withdrawn; the stage waits for ack or timeout, then goes to IDLE with no write-back and no excp_buserr.
- Simultaneous ack and timeout in the same cycle: ack wins.
- Reset mid-BUSY: bus_req drops in the cycle after the reset edge; a late ack arriving in IDLE is ignored.

Decomposition:
- Shared defines header (alongside the existing RstEnable/WriteDisable/ZeroWord/NOPRegAddr macros): mem_op encodings MemOpNone..MemOpSW, and the FSM state encodings.
- One natural sub-module, mem_lane, which is combinational:
  - Inputs: op, addr[1:0], store data, read data.
  - Outputs: sel, replicated wdata, extended load data, misalign flag.

Test Plan:
- Reset, then ADD result passthrough: mem_wd=5, mem_wdata=0x1234, mem_op=0 → wb_wdata=0x1234 same cycle, stallreq=0, bus_req=0.
- LB at addr 0x101, 2-cycle ack, rdata=0x11AA2233 → bus_sel=0100, stallreq high 2 cycles; DONE shows wb_wdata=0xFFFFFFAA.
- LHU at addr 0x102, zero-wait ack, rdata=0x1234F00D → stallreq for 1 cycle; wb_wdata=0x0000F00D.
- SH at addr 0x200, sdata=0xDEADBEEF → bus_we=1, bus_sel=1100, bus_wdata=0xBEEFBEEF, wb_wreg=0.
- LW at addr 0x3 → excp_misalign=1, bus_req=0, stallreq=0, wb_wreg=0.
- Two further cases:
  - LW, no ack for TIMEOUT=16 cycles → excp_buserr pulse on cycle 16, state IDLE.
  - Repeat with flush asserted in BUSY → no write-back and no excp_buserr.
